// File: rtl/pipeline_control_chain.sv
// Pipeline control chain: carries decoder control bundles through ID/EX, EX/MEM
// and MEM/WB, detects load-use hazards and generates EX-stage forwarding selects.
module pipeline_control_chain #(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic [1:0]            writeBackControl,
  input  logic [1:0]            memAccessControl,
  input  logic [3:0]            calculationControl,
  input  logic                  idValid,
  input  logic [REG_ADDR_W-1:0] idRs,
  input  logic [REG_ADDR_W-1:0] idRt,
  input  logic [REG_ADDR_W-1:0] idRd,
  input  logic                  branchTaken,
  output logic                  exRegDst,
  output logic                  exAluSrc,
  output logic [1:0]            exAluOp,
  output logic [1:0]            forwardA,
  output logic [1:0]            forwardB,
  output logic                  memRead,
  output logic                  memWrite,
  output logic                  memBranch,
  output logic [REG_ADDR_W-1:0] memDestReg,
  output logic                  wbRegWrite,
  output logic                  wbMemToReg,
  output logic [REG_ADDR_W-1:0] wbDestReg,
  output logic                  stall,
  output logic                  flushIfId
);

  localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
  localparam logic [1:0] FWD_REGFILE   = 2'b00;
  localparam logic [1:0] FWD_EX_MEM    = 2'b10;
  localparam logic [1:0] FWD_MEM_WB    = 2'b01;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef struct packed {
    logic      reg_write;
    logic      mem_to_reg;
    logic      mem_read;
    logic      mem_write;
    logic      reg_dst;
    logic [1:0] alu_op;
    logic      alu_src;
    reg_addr_t rs;
    reg_addr_t rt;
    reg_addr_t rd;
  } id_ex_t;

  typedef struct packed {
    logic      reg_write;
    logic      mem_to_reg;
    logic      mem_read;
    logic      mem_write;
    logic      branch;
    reg_addr_t dest;
  } ex_mem_t;

  typedef struct packed {
    logic      reg_write;
    logic      mem_to_reg;
    reg_addr_t dest;
  } mem_wb_t;

  id_ex_t    id_ex_q, id_ex_d;
  ex_mem_t   ex_mem_q, ex_mem_d;
  mem_wb_t   mem_wb_q, mem_wb_d;
  reg_addr_t ex_dest;
  logic      load_use;

  // Load in EX whose target is read by the instruction in ID.
  always_comb begin
    load_use = 1'b0;
    if (id_ex_q.mem_read && idValid &&
        ((id_ex_q.rt == idRs) || (id_ex_q.rt == idRt))) begin
      load_use = 1'b1;
    end
  end

  // A taken branch kills the dependent instruction anyway, so flush wins over stall.
  assign stall     = load_use && !branchTaken;
  assign flushIfId = branchTaken;

  // ID/EX next value: ID bundle, or a bubble when invalid, stalled or flushed.
  always_comb begin
    id_ex_d = '0;
    if (idValid && !stall && !branchTaken) begin
      id_ex_d.reg_write  = writeBackControl[1];
      id_ex_d.mem_to_reg = writeBackControl[0];
      id_ex_d.mem_read   = memAccessControl[1];
      id_ex_d.mem_write  = memAccessControl[0];
      id_ex_d.reg_dst    = calculationControl[3];
      id_ex_d.alu_op     = calculationControl[2:1];
      id_ex_d.alu_src    = calculationControl[0];
      id_ex_d.rs         = idRs;
      id_ex_d.rt         = idRt;
      id_ex_d.rd         = idRd;
    end
  end

  assign ex_dest = id_ex_q.reg_dst ? id_ex_q.rd : id_ex_q.rt;

  // EX/MEM next value: EX fields, or a bubble when the MEM branch is taken.
  always_comb begin
    ex_mem_d = '0;
    if (!branchTaken) begin
      ex_mem_d.reg_write  = id_ex_q.reg_write;
      ex_mem_d.mem_to_reg = id_ex_q.mem_to_reg;
      ex_mem_d.mem_read   = id_ex_q.mem_read;
      ex_mem_d.mem_write  = id_ex_q.mem_write;
      ex_mem_d.branch     = (id_ex_q.alu_op == ALU_OP_BRANCH);
      ex_mem_d.dest       = ex_dest;
    end
  end

  // MEM/WB next value: the branch itself never writes, so this stage is never flushed.
  always_comb begin
    mem_wb_d            = '0;
    mem_wb_d.reg_write  = ex_mem_q.reg_write;
    mem_wb_d.mem_to_reg = ex_mem_q.mem_to_reg;
    mem_wb_d.dest       = ex_mem_q.dest;
  end

  // Pipeline registers; reset fills every stage with a bubble.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      id_ex_q  <= '0;
      ex_mem_q <= '0;
      mem_wb_q <= '0;
    end else begin
      id_ex_q  <= id_ex_d;
      ex_mem_q <= ex_mem_d;
      mem_wb_q <= mem_wb_d;
    end
  end

  // Operand forwarding; the younger EX/MEM result beats MEM/WB, and $0 never matches.
  always_comb begin
    forwardA = FWD_REGFILE;
    forwardB = FWD_REGFILE;
    if (ex_mem_q.reg_write && (ex_mem_q.dest != '0) && (ex_mem_q.dest == id_ex_q.rs)) begin
      forwardA = FWD_EX_MEM;
    end else if (mem_wb_q.reg_write && (mem_wb_q.dest != '0) && (mem_wb_q.dest == id_ex_q.rs)) begin
      forwardA = FWD_MEM_WB;
    end
    if (ex_mem_q.reg_write && (ex_mem_q.dest != '0) && (ex_mem_q.dest == id_ex_q.rt)) begin
      forwardB = FWD_EX_MEM;
    end else if (mem_wb_q.reg_write && (mem_wb_q.dest != '0) && (mem_wb_q.dest == id_ex_q.rt)) begin
      forwardB = FWD_MEM_WB;
    end
  end

  assign exRegDst   = id_ex_q.reg_dst;
  assign exAluOp    = id_ex_q.alu_op;
  assign exAluSrc   = id_ex_q.alu_src;
  assign memRead    = ex_mem_q.mem_read;
  assign memWrite   = ex_mem_q.mem_write;
  assign memBranch  = ex_mem_q.branch;
  assign memDestReg = ex_mem_q.dest;
  assign wbRegWrite = mem_wb_q.reg_write;
  assign wbMemToReg = mem_wb_q.mem_to_reg;
  assign wbDestReg  = mem_wb_q.dest;

endmodule

// File: tb/tb_pipeline_control_chain.sv
// Self-checking bench for pipeline_control_chain: a queue scoreboard tracks the
// expected contents of each pipeline stage, scenario tasks add targeted checks.
module tb_pipeline_control_chain;

  logic       clk;
  logic       rstN;
  logic [1:0] writeBackControl;
  logic [1:0] memAccessControl;
  logic [3:0] calculationControl;
  logic       idValid;
  logic [4:0] idRs, idRt, idRd;
  logic       branchTaken;
  logic       exRegDst, exAluSrc;
  logic [1:0] exAluOp, forwardA, forwardB;
  logic       memRead, memWrite, memBranch;
  logic [4:0] memDestReg;
  logic       wbRegWrite, wbMemToReg;
  logic [4:0] wbDestReg;
  logic       stall, flushIfId;

  pipeline_control_chain #(.REG_ADDR_W(5)) dut (
    .clk(clk), .rstN(rstN),
    .writeBackControl(writeBackControl), .memAccessControl(memAccessControl),
    .calculationControl(calculationControl), .idValid(idValid),
    .idRs(idRs), .idRt(idRt), .idRd(idRd), .branchTaken(branchTaken),
    .exRegDst(exRegDst), .exAluSrc(exAluSrc), .exAluOp(exAluOp),
    .forwardA(forwardA), .forwardB(forwardB),
    .memRead(memRead), .memWrite(memWrite), .memBranch(memBranch), .memDestReg(memDestReg),
    .wbRegWrite(wbRegWrite), .wbMemToReg(wbMemToReg), .wbDestReg(wbDestReg),
    .stall(stall), .flushIfId(flushIfId)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       rw;
    logic       m2r;
    logic       mr;
    logic       mw;
    logic       rdst;
    logic [1:0] aop;
    logic       asrc;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
  } ent_t;

  ent_t  ex_q[$];
  ent_t  mem_q[$];
  ent_t  wb_q[$];
  int    checks = 0;
  int    errors = 0;
  string cur = "none";

  function automatic logic [4:0] dest_of(input ent_t x);
    return x.rdst ? x.rd : x.rt;
  endfunction

  function automatic logic [24:0] all_outs();
    return {exRegDst, exAluSrc, exAluOp, forwardA, forwardB, memRead, memWrite, memBranch,
            memDestReg, wbRegWrite, wbMemToReg, wbDestReg, stall, flushIfId};
  endfunction

  task automatic sb_reset();
    ex_q.delete(); mem_q.delete(); wb_q.delete();
    ex_q.push_back('0); mem_q.push_back('0); wb_q.push_back('0);
  endtask

  // One cycle: drive ID at negedge, check combinational controls, advance the
  // scoreboard, then check every stage after the rising edge.
  task automatic tick(input logic v, input logic [1:0] wb, input logic [1:0] mem,
                      input logic [3:0] calc, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic br, input logic e_stall,
                      input logic [1:0] e_fa, input logic [1:0] e_fb);
    ent_t nw, e, m;
    logic [5:0] c_got, c_exp;
    logic [3:0] x_got, x_exp;
    logic [7:0] m_got, m_exp;
    logic [6:0] w_got, w_exp;
    @(negedge clk);
    idValid = v; writeBackControl = wb; memAccessControl = mem; calculationControl = calc;
    idRs = rs; idRt = rt; idRd = rd; branchTaken = br;
    #1;
    c_got = {stall, flushIfId, forwardA, forwardB};
    c_exp = {e_stall, br, e_fa, e_fb};
    checks++;
    if (c_got !== c_exp) begin
      errors++;
      $display("FAIL %s ctrl {stall,flush,fwdA,fwdB}: got %b expected %b", cur, c_got, c_exp);
    end
    nw = '0;
    if (v && !e_stall && !br) nw = {wb, mem, calc, rs, rt, rd};
    e = ex_q.pop_front();
    m = mem_q.pop_front();
    wb_q.delete(0);
    wb_q.push_back(m);
    mem_q.push_back(br ? ent_t'('0) : e);
    ex_q.push_back(nw);
    @(posedge clk);
    #1;
    x_got = {exRegDst, exAluOp, exAluSrc};
    x_exp = {ex_q[0].rdst, ex_q[0].aop, ex_q[0].asrc};
    m_got = {memRead, memWrite, memBranch, memDestReg};
    m_exp = {mem_q[0].mr, mem_q[0].mw, (mem_q[0].aop == 2'b01), dest_of(mem_q[0])};
    w_got = {wbRegWrite, wbMemToReg, wbDestReg};
    w_exp = {wb_q[0].rw, wb_q[0].m2r, dest_of(wb_q[0])};
    checks += 3;
    if (x_got !== x_exp) begin
      errors++;
      $display("FAIL %s ex stage: got %b expected %b", cur, x_got, x_exp);
    end
    if (m_got !== m_exp) begin
      errors++;
      $display("FAIL %s mem stage: got %b expected %b", cur, m_got, m_exp);
    end
    if (w_got !== w_exp) begin
      errors++;
      $display("FAIL %s wb stage: got %b expected %b", cur, w_got, w_exp);
    end
  endtask

  task automatic rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic st, input logic [1:0] fa, input logic [1:0] fb);
    tick(1'b1, 2'b10, 2'b00, 4'b1100, rs, rt, rd, 1'b0, st, fa, fb);
  endtask

  task automatic load(input logic [4:0] rs, input logic [4:0] rt,
                      input logic [1:0] fa, input logic [1:0] fb);
    tick(1'b1, 2'b11, 2'b10, 4'b0001, rs, rt, 5'd0, 1'b0, 1'b0, fa, fb);
  endtask

  task automatic bub(input logic [1:0] fa, input logic [1:0] fb);
    tick(1'b0, 2'b00, 2'b00, 4'b0000, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, fa, fb);
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) bub(2'b00, 2'b00);
  endtask

  task automatic test_reset();
    cur = "reset";
    rstN = 1'b1; idValid = 1'b0; writeBackControl = '0; memAccessControl = '0;
    calculationControl = '0; idRs = '0; idRt = '0; idRd = '0; branchTaken = 1'b0;
    #1 rstN = 1'b0;
    #12;
    checks++;
    if (all_outs() !== 25'd0) begin
      errors++;
      $display("FAIL reset outputs: got %h expected 0", all_outs());
    end
    @(negedge clk);
    rstN = 1'b1;
    sb_reset();
  endtask

  task automatic test_rformat();
    cur = "rformat";
    rtype(5'd1, 5'd2, 5'd3, 1'b0, 2'b00, 2'b00);
    checks++;
    if ({exRegDst, exAluOp} !== 3'b110) begin
      errors++;
      $display("FAIL rformat ex ctrl: got %b expected 110", {exRegDst, exAluOp});
    end
    bub(2'b00, 2'b00);
    checks++;
    if (memDestReg !== 5'd3) begin
      errors++;
      $display("FAIL rformat memDestReg: got %0d expected 3", memDestReg);
    end
    bub(2'b00, 2'b00);
    checks++;
    if ({wbRegWrite, wbDestReg} !== {1'b1, 5'd3}) begin
      errors++;
      $display("FAIL rformat wb: got %b expected 100011", {wbRegWrite, wbDestReg});
    end
    bub(2'b00, 2'b00);
    cur = "store";
    tick(1'b1, 2'b00, 2'b01, 4'b0001, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00);
    drain();
  endtask

  task automatic test_load_use();
    cur = "load_use_rs";
    load(5'd1, 5'd5, 2'b00, 2'b00);
    rtype(5'd5, 5'd6, 5'd7, 1'b1, 2'b00, 2'b00);
    checks++;
    if ({exRegDst, exAluOp, exAluSrc, memRead} !== 5'b00001) begin
      errors++;
      $display("FAIL load_use bubble: got %b expected 00001", {exRegDst, exAluOp, exAluSrc, memRead});
    end
    rtype(5'd5, 5'd6, 5'd7, 1'b0, 2'b00, 2'b00);
    bub(2'b01, 2'b00);
    drain();
    cur = "load_use_rt";
    load(5'd1, 5'd5, 2'b00, 2'b00);
    rtype(5'd7, 5'd5, 5'd8, 1'b1, 2'b00, 2'b00);
    rtype(5'd7, 5'd5, 5'd8, 1'b0, 2'b00, 2'b00);
    bub(2'b00, 2'b01);
    drain();
    cur = "load_no_valid";
    load(5'd1, 5'd5, 2'b00, 2'b00);
    tick(1'b0, 2'b10, 2'b00, 4'b1100, 5'd5, 5'd5, 5'd9, 1'b0, 1'b0, 2'b00, 2'b00);
    drain();
  endtask

  task automatic test_forwarding();
    cur = "fwd_adjacent";
    rtype(5'd1, 5'd2, 5'd4, 1'b0, 2'b00, 2'b00);
    rtype(5'd4, 5'd4, 5'd8, 1'b0, 2'b00, 2'b00);
    bub(2'b10, 2'b10);
    drain();
    cur = "fwd_gap";
    rtype(5'd1, 5'd2, 5'd4, 1'b0, 2'b00, 2'b00);
    bub(2'b00, 2'b00);
    rtype(5'd4, 5'd4, 5'd9, 1'b0, 2'b00, 2'b00);
    bub(2'b01, 2'b01);
    drain();
    cur = "fwd_priority";
    rtype(5'd1, 5'd2, 5'd4, 1'b0, 2'b00, 2'b00);
    rtype(5'd1, 5'd2, 5'd4, 1'b0, 2'b00, 2'b00);
    rtype(5'd4, 5'd4, 5'd10, 1'b0, 2'b00, 2'b00);
    bub(2'b10, 2'b10);
    drain();
    cur = "fwd_mixed";
    rtype(5'd1, 5'd2, 5'd4, 1'b0, 2'b00, 2'b00);
    rtype(5'd1, 5'd2, 5'd6, 1'b0, 2'b00, 2'b00);
    rtype(5'd4, 5'd6, 5'd11, 1'b0, 2'b00, 2'b00);
    bub(2'b01, 2'b10);
    drain();
  endtask

  task automatic test_reg0();
    cur = "reg0";
    rtype(5'd1, 5'd2, 5'd0, 1'b0, 2'b00, 2'b00);
    rtype(5'd0, 5'd0, 5'd11, 1'b0, 2'b00, 2'b00);
    bub(2'b00, 2'b00);
    drain();
  endtask

  task automatic test_branch_flush();
    cur = "branch";
    tick(1'b1, 2'b00, 2'b00, 4'b0010, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00);
    load(5'd3, 5'd6, 2'b00, 2'b00);
    checks++;
    if (memBranch !== 1'b1) begin
      errors++;
      $display("FAIL branch memBranch: got %b expected 1", memBranch);
    end
    // Load-use pair in ID/EX while the branch in MEM is taken: flush, no stall.
    tick(1'b1, 2'b10, 2'b00, 4'b1100, 5'd6, 5'd1, 5'd12, 1'b1, 1'b0, 2'b00, 2'b00);
    checks++;
    if ({exRegDst, exAluOp, exAluSrc, memRead, memWrite, memBranch, memDestReg, wbRegWrite} !== 13'd0) begin
      errors++;
      $display("FAIL branch flushed stages: got %b expected 0",
               {exRegDst, exAluOp, exAluSrc, memRead, memWrite, memBranch, memDestReg, wbRegWrite});
    end
    drain();
  endtask

  task automatic test_reset_midstream();
    cur = "reset_mid";
    load(5'd1, 5'd5, 2'b00, 2'b00);
    @(negedge clk);
    idValid = 1'b1; writeBackControl = 2'b10; memAccessControl = 2'b00;
    calculationControl = 4'b1100; idRs = 5'd5; idRt = 5'd6; idRd = 5'd7;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid pre-reset stall: got %b expected 1", stall);
    end
    #1 rstN = 1'b0;
    #1;
    checks++;
    if (all_outs() !== 25'd0) begin
      errors++;
      $display("FAIL reset_mid async clear: got %h expected 0", all_outs());
    end
    idValid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (all_outs() !== 25'd0) begin
      errors++;
      $display("FAIL reset_mid held: got %h expected 0", all_outs());
    end
    @(negedge clk);
    rstN = 1'b1;
    sb_reset();
    drain();
    checks++;
    if (all_outs() !== 25'd0) begin
      errors++;
      $display("FAIL reset_mid idle: got %h expected 0", all_outs());
    end
  endtask

  initial begin
    test_reset();
    test_rformat();
    test_load_use();
    test_forwarding();
    test_reg0();
    test_branch_flush();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
